serial_line_collector: RTL

- Sits directly downstream of the quick_rs232 receive interface and directly upstream of its transmit interface, in the serial echo top level.
- Pulls received bytes one at a time into a line buffer.
- On a terminator byte, or when the buffer is full, replays the whole line back through the transmitter as one tx transaction.
- Turns the byte-by-byte echo into line-oriented echo, the base for a later command shell.

---
 rtl/serial_line_collector_if.sv | 29 ++
 rtl/serial_line_collector.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_line_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_line_collector_if
// Purpose  : rx/tx handshake bundle between the RS-232 core and the collector.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_line_collector_if;
    logic       rx_byte_received;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       rx_read;
    logic       tx_transaction;
    logic [7:0] tx_data;
    logic       tx_data_ready;
    logic       tx_data_copied;
    logic       tx_busy;

    // master: the line collector; slave: the RS-232 receive/transmit core
    modport master (
        input  rx_byte_received, rx_data, rx_err, tx_data_copied, tx_busy,
        output rx_read, tx_transaction, tx_data, tx_data_ready
    );

    modport slave (
        output rx_byte_received, rx_data, rx_err, tx_data_copied, tx_busy,
        input  rx_read, tx_transaction, tx_data, tx_data_ready
    );
endinterface
`default_nettype wire

// File: rtl/serial_line_collector.sv
`default_nettype none
// ============================================================================
// Module   : serial_line_collector
// Purpose  : Buffers received bytes into a line and replays it on terminator
//            or full buffer. Option macro: SERIAL_LINE_UPPERCASE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_line_collector #(
    parameter int         BUFFER_LEN       = 64,
    parameter logic [7:0] TERMINATOR       = 8'h0D,
    parameter int         RX_SETTLE_CYCLES = 4,
    parameter int         TX_GAP_CYCLES    = 10
) (
    input  wire logic              clk,
    input  wire logic              rst,
    serial_line_collector_if.master bus,
    output logic [15:0]            line_count,
    output logic                   line_overflow,
    output logic [7:0]             rx_err_count
);

    localparam int PTR_W    = $clog2(BUFFER_LEN) + 1;
    localparam int IDX_W    = PTR_W - 1;
    localparam int MAX_WAIT = (RX_SETTLE_CYCLES > TX_GAP_CYCLES) ? RX_SETTLE_CYCLES : TX_GAP_CYCLES;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(RX_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gap_last    = CNT_W'(TX_GAP_CYCLES - 1);
    localparam logic [PTR_W-1:0] c_full        = PTR_W'(BUFFER_LEN);

    typedef enum logic [2:0] {
        IDLE            = 3'd0,
        RX_SETTLE       = 3'd1,
        TX_LOAD         = 3'd2,
        TX_WAIT_COPY    = 3'd3,
        TX_WAIT_RELEASE = 3'd4,
        TX_GAP          = 3'd5,
        TX_FIN          = 3'd6
    } state_t;

    state_t           r_state, w_state_next;
    logic [PTR_W-1:0] r_wr_ptr, w_wr_ptr_next;
    logic [PTR_W-1:0] r_rd_ptr, w_rd_ptr_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_last_term, w_last_term_next;
    logic             r_rx_read, w_rx_read_next;
    logic             r_tx_transaction, w_tx_transaction_next;
    logic [7:0]       r_tx_data, w_tx_data_next;
    logic             r_tx_data_ready, w_tx_data_ready_next;
    logic [15:0]      r_line_count, w_line_count_next;
    logic             r_line_overflow, w_line_overflow_next;
    logic [7:0]       r_rx_err_count, w_rx_err_count_next;
    logic             w_buf_we;
    logic             w_unused_tx_busy;

    logic [7:0] r_buf [BUFFER_LEN];

    function automatic logic [7:0] tx_xform(input logic [7:0] b);
`ifdef SERIAL_LINE_UPPERCASE_EN
        return (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
`else
        return b;
`endif
    endfunction

    // Line storage carries no reset; only the pointers define valid content.
    always_ff @(posedge clk) begin
        if (w_buf_we)
            r_buf[r_wr_ptr[IDX_W-1:0]] <= bus.rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_cnt            <= '0;
            r_last_term      <= 1'b0;
            r_rx_read        <= 1'b0;
            r_tx_transaction <= 1'b0;
            r_tx_data        <= 8'h00;
            r_tx_data_ready  <= 1'b0;
            r_line_count     <= 16'h0000;
            r_line_overflow  <= 1'b0;
            r_rx_err_count   <= 8'h00;
        end else begin
            r_state          <= w_state_next;
            r_wr_ptr         <= w_wr_ptr_next;
            r_rd_ptr         <= w_rd_ptr_next;
            r_cnt            <= w_cnt_next;
            r_last_term      <= w_last_term_next;
            r_rx_read        <= w_rx_read_next;
            r_tx_transaction <= w_tx_transaction_next;
            r_tx_data        <= w_tx_data_next;
            r_tx_data_ready  <= w_tx_data_ready_next;
            r_line_count     <= w_line_count_next;
            r_line_overflow  <= w_line_overflow_next;
            r_rx_err_count   <= w_rx_err_count_next;
        end
    end

    always_comb begin
        w_state_next          = r_state;
        w_wr_ptr_next         = r_wr_ptr;
        w_rd_ptr_next         = r_rd_ptr;
        w_cnt_next            = r_cnt;
        w_last_term_next      = r_last_term;
        w_rx_read_next        = 1'b0;
        w_tx_transaction_next = r_tx_transaction;
        w_tx_data_next        = r_tx_data;
        w_tx_data_ready_next  = r_tx_data_ready;
        w_line_count_next     = r_line_count;
        w_line_overflow_next  = 1'b0;
        w_rx_err_count_next   = r_rx_err_count;
        w_buf_we              = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.rx_byte_received) begin
                    w_rx_read_next = 1'b1;
                    if (!bus.rx_err) begin
                        w_buf_we         = 1'b1;
                        w_wr_ptr_next    = r_wr_ptr + 1'b1;
                        w_last_term_next = (bus.rx_data == TERMINATOR);
                    end else if (r_rx_err_count != 8'hFF) begin
                        w_rx_err_count_next = r_rx_err_count + 1'b1;
                    end
                    w_cnt_next   = '0;
                    w_state_next = RX_SETTLE;
                end
            end
            RX_SETTLE: begin
                if (r_cnt == c_settle_last) begin
                    w_cnt_next = '0;
                    if (r_last_term || (r_wr_ptr == c_full)) begin
                        w_rd_ptr_next        = '0;
                        w_line_overflow_next = !r_last_term;
                        w_state_next         = TX_LOAD;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            TX_LOAD: begin
                w_tx_transaction_next = 1'b1;
                w_tx_data_next        = tx_xform(r_buf[r_rd_ptr[IDX_W-1:0]]);
                w_tx_data_ready_next  = 1'b1;
                w_state_next          = TX_WAIT_COPY;
            end
            TX_WAIT_COPY: begin
                if (bus.tx_data_copied) begin
                    w_tx_data_ready_next = 1'b0;
                    w_state_next         = TX_WAIT_RELEASE;
                end
            end
            TX_WAIT_RELEASE: begin
                if (!bus.tx_data_copied) begin
                    w_rd_ptr_next = r_rd_ptr + 1'b1;
                    w_cnt_next    = '0;
                    w_state_next  = TX_GAP;
                end
            end
            TX_GAP: begin
                if (r_cnt == c_gap_last) begin
                    w_cnt_next   = '0;
                    w_state_next = (r_rd_ptr == r_wr_ptr) ? TX_FIN : TX_LOAD;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            TX_FIN: begin
                if (r_cnt == c_gap_last) begin
                    w_cnt_next            = '0;
                    w_tx_transaction_next = 1'b0;
                    w_line_count_next     = r_line_count + 1'b1;
                    w_wr_ptr_next         = '0;
                    w_last_term_next      = 1'b0;
                    w_state_next          = IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Transmitter busy is informational; pacing comes from tx_data_copied.
    assign w_unused_tx_busy   = bus.tx_busy;

    assign bus.rx_read        = r_rx_read;
    assign bus.tx_transaction = r_tx_transaction;
    assign bus.tx_data        = r_tx_data;
    assign bus.tx_data_ready  = r_tx_data_ready;
    assign line_count         = r_line_count;
    assign line_overflow      = r_line_overflow;
    assign rx_err_count       = r_rx_err_count;

endmodule
`default_nettype wire
